// File: rtl/kanagawa_fifo_write_arbiter.sv
// kanagawa_fifo_write_arbiter
//
// Shares a single FIFO write port among NUM_REQ requesters. Arbitration is
// round-robin; a multi-beat packet locks the port to its requester until the
// beat flagged req_last is granted. FIFO occupancy is tracked here as credits
// (used), so grants stop exactly when the FIFO would overflow without waiting
// on a far-away almost_full. The granted beat travels WRITE_DELAY register
// stages toward the FIFO datapath, and the FIFO's empty flag is derived from
// that delayed write stream together with the consumer's rdreq.
//
// Handshake: a requester raises req[i] (with req_last[i]) and holds it until
// a cycle in which grant[i] is high; the beat transfers in exactly that cycle
// (req[i] & grant[i]). grant is combinational and may be low while req is
// high (stall); the requester must keep req[i] asserted through the stall.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req         per-requester write request (held until granted)
//   req_last    last-beat-of-packet flag, sampled with req
//   grant       one-hot (or zero) grant, same cycle as req
//   wr_valid    FIFO write strobe, WRITE_DELAY cycles after grant
//   wr_sel      index of the requester whose beat is being written
//   wr_last     req_last of the written beat
//   rdreq       consumer read strobe
//   empty       no landed entries in the FIFO
//   used        reserved entries (granted but not yet read)
//
// The arbiter FSM state is visible as the internal signal `state`
// (ARB / LOCK) along with rr_ptr and lock_id for checkers to bind to.

module kanagawa_fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_DEPTH   = 5,
  parameter int MAX_SIZE    = 2 ** LOG_DEPTH,
  parameter int WRITE_DELAY = 2,
  parameter int SEL_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] grant,
  output logic               wr_valid,
  output logic [SEL_W-1:0]   wr_sel,
  output logic               wr_last,
  input  logic               rdreq,
  output logic               empty,
  output logic [LOG_DEPTH:0] used
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [LOG_DEPTH:0] MAX_USED = (LOG_DEPTH + 1)'(MAX_SIZE);

  state_t             state, state_next;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_next;
  logic [SEL_W-1:0]   lock_id, lock_id_next;
  logic               can_grant;
  logic               win_found;
  logic [SEL_W-1:0]   win_id;
  logic               cur_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               cur_last;
  logic [LOG_DEPTH:0] used_next;
  logic [LOG_DEPTH:0] landed, landed_next;

  // Credits come from the registered count only; a read in this cycle frees
  // a slot for the next cycle, never for the current one.
  assign can_grant = (used < MAX_USED);

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[SEL_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = SEL_W'(idx);
      end
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    lock_id_next = lock_id;
    grant        = '0;
    cur_valid    = 1'b0;
    cur_sel      = '0;
    cur_last     = 1'b0;

    case (state)
      ARB: begin
        if (can_grant && win_found) begin
          cur_valid = 1'b1;
          cur_sel   = win_id;
        end
      end
      LOCK: begin
        // Only the packet owner may proceed; everyone else waits.
        if (can_grant && req[lock_id]) begin
          cur_valid = 1'b1;
          cur_sel   = lock_id;
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase

    if (cur_valid) begin
      grant[cur_sel] = 1'b1;
      cur_last       = req_last[cur_sel];
      rr_ptr_next    = cur_sel;
      if (cur_last) begin
        state_next = ARB;
      end else begin
        state_next   = LOCK;
        lock_id_next = cur_sel;
      end
    end
  end

  assign used_next   = used + (LOG_DEPTH + 1)'(cur_valid) - (LOG_DEPTH + 1)'(rdreq);
  assign landed_next = landed + (LOG_DEPTH + 1)'(wr_valid) - (LOG_DEPTH + 1)'(rdreq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      rr_ptr  <= SEL_W'(NUM_REQ - 1);
      lock_id <= '0;
      used    <= '0;
      landed  <= '0;
      empty   <= 1'b1;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      lock_id <= lock_id_next;
      used    <= used_next;
      landed  <= landed_next;
      empty   <= (landed_next == '0);
    end
  end

  // Outgoing write pipeline: free-running, no enable.
  generate
    if (WRITE_DELAY == 0) begin : g_comb
      assign wr_valid = cur_valid;
      assign wr_sel   = cur_sel;
      assign wr_last  = cur_last;
    end else begin : g_pipe
      logic [WRITE_DELAY-1:0] pipe_valid;
      logic [WRITE_DELAY-1:0] pipe_last;
      logic [SEL_W-1:0]       pipe_sel [WRITE_DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_valid <= '0;
          pipe_last  <= '0;
          for (int i = 0; i < WRITE_DELAY; i++) pipe_sel[i] <= '0;
        end else begin
          pipe_valid[0] <= cur_valid;
          pipe_last[0]  <= cur_last;
          pipe_sel[0]   <= cur_sel;
          for (int i = 1; i < WRITE_DELAY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_last[i]  <= pipe_last[i-1];
            pipe_sel[i]   <= pipe_sel[i-1];
          end
        end
      end

      assign wr_valid = pipe_valid[WRITE_DELAY-1];
      assign wr_sel   = pipe_sel[WRITE_DELAY-1];
      assign wr_last  = pipe_last[WRITE_DELAY-1];
    end
  endgenerate

`ifndef NO_DYNAMIC_ASSERTS
  a_underflow: assert property (@(posedge clk) disable iff (rst) !(rdreq && empty))
    else $error("fifo underflow: rdreq while empty");
  a_used_max: assert property (@(posedge clk) disable iff (rst) used <= MAX_USED)
    else $error("used exceeds MAX_SIZE");
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant))
    else $error("grant not onehot0");
  a_grant_req: assert property (@(posedge clk) disable iff (rst) (grant & ~req) == '0)
    else $error("grant without req");
  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
      a_req_hold: assert property (@(posedge clk)
        (!rst && req[g] && !grant[g]) |=> (req[g] || rst))
        else $error("req dropped before grant");
    end
  endgenerate
`endif

endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
module tb_kanagawa_fifo_write_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int LOG_DEPTH   = 5;
  localparam int MAX_SIZE    = 32;
  localparam int WRITE_DELAY = 2;
  localparam int SEL_W       = 2;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] grant;
  logic               wr_valid;
  logic [SEL_W-1:0]   wr_sel;
  logic               wr_last;
  logic               rdreq;
  logic               empty;
  logic [LOG_DEPTH:0] used;

  int checks = 0;
  int errors = 0;

  // Expected {wr_sel, wr_last} of each beat, in grant order.
  logic [SEL_W:0] exp_q[$];

  kanagawa_fifo_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LOG_DEPTH  (LOG_DEPTH),
    .MAX_SIZE   (MAX_SIZE),
    .WRITE_DELAY(WRITE_DELAY),
    .SEL_W      (SEL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_last(req_last),
    .grant   (grant),
    .wr_valid(wr_valid),
    .wr_sel  (wr_sel),
    .wr_last (wr_last),
    .rdreq   (rdreq),
    .empty   (empty),
    .used    (used)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; req_last = '0; rdreq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs just after the edge, returns 2 time units in.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rd);
    @(posedge clk); #1;
    req = r; req_last = l; rdreq = rd;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checks the grant and, when a grant is expected, queues the beat it must produce.
  task automatic exp_grant(input string nm, input logic [3:0] g, input logic l);
    logic [SEL_W-1:0] s;
    s = '0;
    chk(nm, 32'(grant), 32'(g));
    if (g != 4'b0000) begin
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) s = SEL_W'(i);
      exp_q.push_back({s, l});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got sel=%0d last=%0b expected no write at %0t",
                 wr_sel, wr_last, $time);
      end else begin
        logic [SEL_W:0] e;
        e = exp_q.pop_front();
        if ({wr_sel, wr_last} !== e) begin
          errors++;
          $display("FAIL wr_beat: got sel=%0d last=%0b expected sel=%0d last=%0b at %0t",
                   wr_sel, wr_last, e[SEL_W:1], e[0], $time);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = '0; req_last = '0; rdreq = 1'b0;
    reset_dut();

    // Reset state
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_wr_sel", 32'(wr_sel), 32'h0);
    chk("rst_wr_last", 32'(wr_last), 32'h0);
    chk("rst_used", 32'(used), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);

    // All requesting, all single-beat: strict rotation 0,1,2,3 until credits run out
    for (int k = 0; k < 32; k++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      chk("rot_used", 32'(used), 32'(k));
      exp_grant("rot_grant", 4'(1 << (k % 4)), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      chk("full_used", 32'(used), 32'd32);
      exp_grant("full_grant", 4'b0000, 1'b1);
    end

    // Full: a read frees one credit, usable only the following cycle
    drive(4'b1111, 4'b1111, 1'b1);
    chk("rd_cycle_used", 32'(used), 32'd32);
    exp_grant("rd_cycle_grant", 4'b0000, 1'b1);
    drive(4'b1111, 4'b1111, 1'b0);
    chk("after_rd_used", 32'(used), 32'd31);
    exp_grant("after_rd_grant", 4'b0001, 1'b1);
    drive(4'b1111, 4'b1111, 1'b0);
    chk("refull_used", 32'(used), 32'd32);
    exp_grant("refull_grant", 4'b0000, 1'b1);
    drive(4'b1111, 4'b1111, 1'b0);
    drive(4'b1111, 4'b1111, 1'b0);
    chk("full_drain_q", 32'(exp_q.size()), 32'd0);
    reset_dut();

    // Packet lock: req[2] 3-beat packet while req[0], req[1] wait
    drive(4'b0001, 4'b0001, 1'b0); exp_grant("pk_g0", 4'b0001, 1'b1);
    drive(4'b0010, 4'b0010, 1'b0); exp_grant("pk_g1", 4'b0010, 1'b1);
    drive(4'b0111, 4'b0011, 1'b0); exp_grant("pk_b1", 4'b0100, 1'b0);
    drive(4'b0111, 4'b0011, 1'b0); exp_grant("pk_b2", 4'b0100, 1'b0);
    drive(4'b0111, 4'b0111, 1'b0); exp_grant("pk_b3", 4'b0100, 1'b1);
    drive(4'b1011, 4'b1011, 1'b0); exp_grant("pk_rr3", 4'b1000, 1'b1);
    drive(4'b0011, 4'b0011, 1'b0); exp_grant("pk_rr0", 4'b0001, 1'b1);
    drive(4'b0010, 4'b0010, 1'b0); exp_grant("pk_rr1", 4'b0010, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0); exp_grant("pk_idle", 4'b0000, 1'b0);
    chk("pk_used", 32'(used), 32'd8);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("pk_drain_q", 32'(exp_q.size()), 32'd0);
    reset_dut();

    // Lock with credits exhausted mid-packet
    for (int k = 0; k < 31; k++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      exp_grant("lf_fill", 4'b0001, 1'b1);
    end
    drive(4'b0011, 4'b0001, 1'b0); exp_grant("lf_b1", 4'b0010, 1'b0);
    drive(4'b0011, 4'b0001, 1'b0); exp_grant("lf_stall", 4'b0000, 1'b0);
    chk("lf_used_full", 32'(used), 32'd32);
    drive(4'b0011, 4'b0001, 1'b1); exp_grant("lf_rd1", 4'b0000, 1'b0);
    drive(4'b0011, 4'b0001, 1'b0); exp_grant("lf_b2", 4'b0010, 1'b0);
    drive(4'b0011, 4'b0011, 1'b1); exp_grant("lf_rd2", 4'b0000, 1'b0);
    drive(4'b0011, 4'b0011, 1'b0); exp_grant("lf_b3", 4'b0010, 1'b1);
    drive(4'b0001, 4'b0001, 1'b1); exp_grant("lf_rd3", 4'b0000, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0); exp_grant("lf_req0", 4'b0001, 1'b1);
    chk("lf_used_end", 32'(used), 32'd31);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("lf_drain_q", 32'(exp_q.size()), 32'd0);
    reset_dut();

    // Single-grant latency: grant at cycle 10, wr_valid at 12, empty low at 13
    for (int k = 1; k < 10; k++) drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0); exp_grant("lat_grant", 4'b0001, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("lat_c11_wr_valid", 32'(wr_valid), 32'h0);
    chk("lat_c11_used", 32'(used), 32'd1);
    chk("lat_c11_empty", 32'(empty), 32'h1);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("lat_c12_wr_valid", 32'(wr_valid), 32'h1);
    chk("lat_c12_empty", 32'(empty), 32'h1);
    drive(4'b0000, 4'b0000, 1'b1);
    chk("lat_c13_empty", 32'(empty), 32'h0);
    chk("lat_c13_used", 32'(used), 32'd1);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("lat_c14_empty", 32'(empty), 32'h1);
    chk("lat_c14_used", 32'(used), 32'd0);
    reset_dut();

    // Reset mid-packet with two beats in flight
    drive(4'b0100, 4'b0000, 1'b0); exp_grant("mr_b1", 4'b0100, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0); exp_grant("mr_b2", 4'b0100, 1'b0);
    exp_q.delete();
    reset_dut();
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_wr_valid", 32'(wr_valid), 32'h0);
    chk("mr_used", 32'(used), 32'd0);
    chk("mr_empty", 32'(empty), 32'h1);
    drive(4'b1111, 4'b1111, 1'b0); exp_grant("mr_prio0", 4'b0001, 1'b1);
    drive(4'b1110, 4'b1110, 1'b0); exp_grant("mr_g1", 4'b0010, 1'b1);
    drive(4'b1100, 4'b1100, 1'b0); exp_grant("mr_g2", 4'b0100, 1'b1);
    drive(4'b1000, 4'b1000, 1'b0); exp_grant("mr_g3", 4'b1000, 1'b1);
    for (int k = 0; k < 4; k++) drive(4'b0000, 4'b0000, 1'b0);
    chk("mr_used_end", 32'(used), 32'd4);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
